// File: rtl/cam_dvp_pixel_assembler_pkg.sv
// Shared definitions for the DVP pixel assembler: FSM state encoding and
// the layout of the 17-bit word pushed into the camera-side FIFO.
package cam_dvp_pixel_assembler_pkg;

  localparam int CAM_WORD_W  = 17;  // {sof, rgb565}
  localparam int CAM_SOF_BIT = 16;  // first pixel of frame marker

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,  // waiting for the first vsync after reset
    S_BLANK = 2'd1,  // vertical blank, waiting for the frame to open
    S_FRAME = 2'd2   // active frame, capturing pixels
  } cam_state_e;

endpackage

// File: rtl/cam_dvp_pixel_assembler_if.sv
// Camera DVP bus plus the FIFO write port of the pixel assembler.
//   cam_vsync / cam_href / cam_data : camera byte stream (PCLK domain)
//   out_full                        : FIFO full
//   out_wr_en / out_data            : FIFO write strobe and {sof, rgb565}
// master = camera/FIFO side, slave = the assembler.
interface cam_dvp_pixel_assembler_if;
  import cam_dvp_pixel_assembler_pkg::*;

  logic                  cam_vsync;
  logic                  cam_href;
  logic [7:0]            cam_data;
  logic                  out_full;
  logic                  out_wr_en;
  logic [CAM_WORD_W-1:0] out_data;

  modport master (
    output cam_vsync, cam_href, cam_data, out_full,
    input  out_wr_en, out_data
  );

  modport slave (
    input  cam_vsync, cam_href, cam_data, out_full,
    output out_wr_en, out_data
  );

endinterface

// File: rtl/cam_dvp_pixel_assembler_sampler.sv
// Registers the raw DVP pins once and derives edge pulses from the
// registered copies.
//   clk, reset_n          : PCLK, async active-low reset
//   vsync_i/href_i/data_i : raw camera pins
//   vsync_q_o/href_q_o/data_q_o : registered pins
//   vs_rise_o/vs_fall_o   : vsync_q edges
//   href_fall_o           : href_q falling edge (line end)
module cam_dvp_pixel_assembler_sampler (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] data_i,
  output logic       vsync_q_o,
  output logic       href_q_o,
  output logic [7:0] data_q_o,
  output logic       vs_rise_o,
  output logic       vs_fall_o,
  output logic       href_fall_o
);

  logic       vsync_q, vsync_prev_q;
  logic       href_q, href_prev_q;
  logic [7:0] data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_q       <= 1'b0;
      href_prev_q  <= 1'b0;
      data_q       <= 8'h00;
    end else begin
      vsync_q      <= vsync_i;
      vsync_prev_q <= vsync_q;
      href_q       <= href_i;
      href_prev_q  <= href_q;
      data_q       <= data_i;
    end
  end

  assign vsync_q_o   = vsync_q;
  assign href_q_o    = href_q;
  assign data_q_o    = data_q;
  assign vs_rise_o   = vsync_q & ~vsync_prev_q;
  assign vs_fall_o   = ~vsync_q & vsync_prev_q;
  assign href_fall_o = ~href_q & href_prev_q;

endmodule

// File: rtl/cam_dvp_pixel_assembler.sv
// Pairs DVP bytes into RGB565 pixels, tags the first pixel of each frame
// and pushes {sof, rgb565} words into the camera-side FIFO. Checks frame
// geometry and reports line/frame and FIFO overflow errors.
//   clk, reset_n : PCLK, async active-low reset
//   bus          : DVP inputs + FIFO write port (slave modport)
//   frame_done   : 1-cycle pulse at the end of each captured frame
//   frame_err    : geometry error of the last completed frame
//   overflow     : a pixel was dropped on out_full in the current frame
//   frame_cnt    : completed-frame counter, wraps
module cam_dvp_pixel_assembler
  import cam_dvp_pixel_assembler_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic                   clk,
  input  logic                   reset_n,
  cam_dvp_pixel_assembler_if.slave bus,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic                   overflow,
  output logic [7:0]             frame_cnt
);

  localparam int XW = $clog2(FRAME_WIDTH + 2);
  localparam int LW = $clog2(FRAME_HEIGHT + 2);
  localparam logic [XW-1:0] X_MAX = XW'(FRAME_WIDTH);
  localparam logic [XW-1:0] X_SAT = XW'(FRAME_WIDTH + 1);
  localparam logic [LW-1:0] L_MAX = LW'(FRAME_HEIGHT);
  localparam logic [LW-1:0] L_SAT = LW'(FRAME_HEIGHT + 1);

  logic       vsync_q, href_q, vs_rise, vs_fall, href_fall;
  logic [7:0] data_q;

  cam_dvp_pixel_assembler_sampler u_sampler (
    .clk         (clk),
    .reset_n     (reset_n),
    .vsync_i     (bus.cam_vsync),
    .href_i      (bus.cam_href),
    .data_i      (bus.cam_data),
    .vsync_q_o   (vsync_q),
    .href_q_o    (href_q),
    .data_q_o    (data_q),
    .vs_rise_o   (vs_rise),
    .vs_fall_o   (vs_fall),
    .href_fall_o (href_fall)
  );

  cam_state_e            state_q;
  logic [XW-1:0]         x_cnt_q;
  logic [LW-1:0]         line_cnt_q, line_cnt_d;
  logic                  line_err_q, line_err_d;
  logic                  phase_q, sof_arm_q;
  logic [7:0]            byte_hi_q;
  logic                  out_wr_en_q, frame_done_q, frame_err_q, overflow_q;
  logic [CAM_WORD_W-1:0] out_data_q;
  logic [7:0]            frame_cnt_q;
  logic                  capture, line_end, pix_in_range;

  // Line accounting is computed combinationally so a line closed by a
  // vsync rise is already counted in the frame_err of that same cycle.
  always_comb begin
    capture      = (state_q == S_FRAME) && href_q && !vsync_q;
    line_end     = (state_q == S_FRAME) && (href_fall || (vs_rise && href_q));
    pix_in_range = (x_cnt_q < X_MAX) && (line_cnt_q < L_MAX);
    line_cnt_d   = line_cnt_q;
    line_err_d   = line_err_q;
    if (line_end) begin
      if (line_cnt_q != L_SAT) line_cnt_d = line_cnt_q + 1'b1;
      // short/long line, or a dangling odd byte
      if ((x_cnt_q != X_MAX) || phase_q) line_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_SYNC;
      x_cnt_q      <= '0;
      line_cnt_q   <= '0;
      line_err_q   <= 1'b0;
      phase_q      <= 1'b0;
      sof_arm_q    <= 1'b0;
      byte_hi_q    <= 8'h00;
      out_wr_en_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      frame_cnt_q  <= 8'h00;
    end else begin
      out_wr_en_q  <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_SYNC: begin
          if (vs_rise) state_q <= S_BLANK;
        end
        S_BLANK: begin
          if (vs_fall) begin
            state_q    <= S_FRAME;
            x_cnt_q    <= '0;
            line_cnt_q <= '0;
            line_err_q <= 1'b0;
            phase_q    <= 1'b0;
            overflow_q <= 1'b0;
            sof_arm_q  <= 1'b1;
          end
        end
        S_FRAME: begin
          line_cnt_q <= line_cnt_d;
          line_err_q <= line_err_d;
          if (line_end) begin
            x_cnt_q <= '0;
            phase_q <= 1'b0;
          end else if (capture) begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
              byte_hi_q <= data_q;
            end else begin
              if (x_cnt_q != X_SAT) x_cnt_q <= x_cnt_q + 1'b1;
              if (pix_in_range) begin
                if (bus.out_full) begin
                  overflow_q <= 1'b1;
                end else begin
                  out_wr_en_q <= 1'b1;
                  out_data_q  <= {sof_arm_q, byte_hi_q, data_q};
                  sof_arm_q   <= 1'b0;  // stays armed if the first pixel drops
                end
              end
            end
          end
          if (vs_rise) begin
            state_q      <= S_BLANK;
            frame_done_q <= 1'b1;
            frame_err_q  <= line_err_d | (line_cnt_d != L_MAX);
            frame_cnt_q  <= frame_cnt_q + 8'd1;
          end
        end
        default: state_q <= S_SYNC;
      endcase
    end
  end

  assign bus.out_wr_en = out_wr_en_q;
  assign bus.out_data  = out_data_q;
  assign frame_done    = frame_done_q;
  assign frame_err     = frame_err_q;
  assign overflow      = overflow_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_cam_dvp_pixel_assembler.sv
// Directed bench for the DVP pixel assembler with a 4x2 frame geometry.
module tb_cam_dvp_pixel_assembler;

  localparam int W = 4;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_done, frame_err, overflow;
  logic [7:0] frame_cnt;

  cam_dvp_pixel_assembler_if bus ();

  cam_dvp_pixel_assembler #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  // Write/frame_done monitor, sampled away from the active edge.
  logic [16:0] wq[$];
  int          done_cnt = 0;
  always @(negedge clk) begin
    if (bus.out_wr_en) wq.push_back(bus.out_data);
    if (frame_done) done_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_line(input int nb, input int base, input logic [31:0] mask);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      bus.cam_href = 1'b1;
      bus.cam_data = 8'(base + i);
      bus.out_full = mask[i];
    end
    @(negedge clk);
    bus.cam_href = 1'b0;
    bus.cam_data = 8'h00;
    bus.out_full = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Line 0 carries bpl0 bytes and the out_full mask; other lines carry bpl.
  task automatic send_frame(input int lines, input int bpl0, input int bpl, input logic [31:0] mask);
    int base;
    base = 0;
    for (int l = 0; l < lines; l++) begin
      send_line((l == 0) ? bpl0 : bpl, base, (l == 0) ? mask : 32'h0);
      base += (l == 0) ? bpl0 : bpl;
    end
  endtask

  task automatic vsync_high();
    @(negedge clk);
    bus.cam_vsync = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic vsync_low();
    @(negedge clk);
    bus.cam_vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    int          lines;
    int          bpl0;
    int          bpl;
    logic [31:0] mask;
    int          n;
    logic [16:0] first;
    logic [16:0] last;
    logic        err;
    logic        ovf;
  } vec_t;

  vec_t        tbl[5];
  logic [16:0] t1[8];
  int          d0;

  initial begin
    tbl[0] = '{2, 8,  8,  32'h0,  8, 17'h1_0001, 17'h0_0E0F, 1'b0, 1'b0}; // clean frame
    tbl[1] = '{2, 8,  8,  32'h60, 7, 17'h1_0001, 17'h0_0E0F, 1'b0, 1'b1}; // full on pixel 2
    tbl[2] = '{2, 7,  8,  32'h0,  7, 17'h1_0001, 17'h0_0D0E, 1'b1, 1'b0}; // odd-length line
    tbl[3] = '{3, 12, 12, 32'h0,  8, 17'h1_0001, 17'h0_1213, 1'b1, 1'b0}; // oversize frame
    tbl[4] = '{2, 8,  8,  32'h6,  7, 17'h1_0203, 17'h0_0E0F, 1'b0, 1'b1}; // full on first pixel
    t1[0] = 17'h1_0001; t1[1] = 17'h0_0203; t1[2] = 17'h0_0405; t1[3] = 17'h0_0607;
    t1[4] = 17'h0_0809; t1[5] = 17'h0_0A0B; t1[6] = 17'h0_0C0D; t1[7] = 17'h0_0E0F;

    bus.cam_vsync = 1'b0;
    bus.cam_href  = 1'b0;
    bus.cam_data  = 8'h00;
    bus.out_full  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(bus.out_wr_en), 32'h0);
    check("rst_data",  32'(bus.out_data),  32'h0);
    check("rst_done",  32'(frame_done),    32'h0);
    check("rst_err",   32'(frame_err),     32'h0);
    check("rst_ovf",   32'(overflow),      32'h0);
    check("rst_fcnt",  32'(frame_cnt),     32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Partial frame after reset is discarded.
    d0 = done_cnt;
    send_frame(2, 8, 8, 32'h0);
    check("sync_writes", 32'(wq.size()), 32'h0);
    vsync_high();
    check("sync_done", 32'(done_cnt - d0), 32'h0);
    vsync_low();

    for (int i = 0; i < 5; i++) begin
      wq.delete();
      d0 = done_cnt;
      send_frame(tbl[i].lines, tbl[i].bpl0, tbl[i].bpl, tbl[i].mask);
      vsync_high();
      check($sformatf("v%0d_writes", i), 32'(wq.size()), 32'(tbl[i].n));
      check($sformatf("v%0d_first", i), (wq.size() > 0) ? 32'(wq[0]) : 32'hDEAD, 32'(tbl[i].first));
      check($sformatf("v%0d_last", i), (wq.size() > 0) ? 32'(wq[wq.size()-1]) : 32'hDEAD, 32'(tbl[i].last));
      check($sformatf("v%0d_done", i), 32'(done_cnt - d0), 32'h1);
      check($sformatf("v%0d_err", i), 32'(frame_err), 32'(tbl[i].err));
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      check($sformatf("v%0d_fcnt", i), 32'(frame_cnt), 32'(i + 1));
      if (i == 0)
        for (int k = 0; k < 8; k++)
          check($sformatf("v0_word%0d", k), (k < wq.size()) ? 32'(wq[k]) : 32'hDEAD, 32'(t1[k]));
      vsync_low();
      check($sformatf("v%0d_ovf_clr", i), 32'(overflow), 32'h0);
    end

    // Asynchronous reset in the middle of a line.
    wq.delete();
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.cam_href = 1'b1;
      bus.cam_data = 8'(i);
    end
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(bus.out_wr_en), 32'h0);
    check("mid_rst_data",  32'(bus.out_data),  32'h0);
    check("mid_rst_err",   32'(frame_err),     32'h0);
    check("mid_rst_fcnt",  32'(frame_cnt),     32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 3; i < 8; i++) begin
      @(negedge clk);
      bus.cam_data = 8'(i);
    end
    @(negedge clk);
    bus.cam_href = 1'b0;
    repeat (3) @(negedge clk);
    send_line(8, 8, 32'h0);
    vsync_high();
    check("post_rst_writes", 32'(wq.size()),       32'h0);
    check("post_rst_done",   32'(done_cnt - d0),   32'h0);
    check("post_rst_fcnt",   32'(frame_cnt),       32'h0);
    vsync_low();
    send_frame(2, 8, 8, 32'h0);
    vsync_high();
    check("post_rst_f_writes", 32'(wq.size()), 32'h8);
    check("post_rst_f_first", (wq.size() > 0) ? 32'(wq[0]) : 32'hDEAD, 32'h1_0001);
    check("post_rst_f_done",  32'(done_cnt - d0), 32'h1);
    check("post_rst_f_fcnt",  32'(frame_cnt),     32'h1);
    vsync_low();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
